// File: rtl/if_stage_pkg.sv
// Shared ISA definitions for the fetch stage: field positions, widths and the if_stage state encoding.
package if_stage_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_W   = 4;
  localparam int REG_ADDR_W = 3;
  localparam int FUNCT_W    = 2;
  localparam int IMM6_W     = 6;

  localparam int OPCODE_LSB = 12;
  localparam int RS_LSB     = 9;
  localparam int RT_LSB     = 6;
  localparam int RD_LSB     = 3;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM6_LSB   = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [FUNCT_W-1:0]    funct;
    logic [IMM6_W-1:0]     imm6;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPCODE_LSB +: OPCODE_W];
    f.rs     = instr[RS_LSB +: REG_ADDR_W];
    f.rt     = instr[RT_LSB +: REG_ADDR_W];
    f.rd     = instr[RD_LSB +: REG_ADDR_W];
    f.funct  = instr[FUNCT_LSB +: FUNCT_W];
    f.imm6   = instr[IMM6_LSB +: IMM6_W];
    return f;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and imem (slave).
interface if_stage_if #(parameter int ADDR_W = 16);
  import if_stage_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage_ifid_pipe_reg.sv
// IF/ID pipeline register with load/hold/flush and the field split consumed by ID.
module ifid_pipe_reg
  import if_stage_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  flush,
  input  logic [INSTR_W-1:0]    instr_in,
  input  logic [PC_WIDTH-1:0]   pc_plus1_in,
  output logic                  valid,
  output logic [INSTR_W-1:0]    instr,
  output logic [PC_WIDTH-1:0]   pc_plus1,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [FUNCT_W-1:0]    funct,
  output logic [IMM6_W-1:0]     imm6
);

  logic                valid_q, valid_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_plus1_q, pc_plus1_d;
  instr_fields_t       fields;

  // Flush only clears valid; the stale word stays visible but is marked as a bubble.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_plus1_d = pc_plus1_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus1_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
    end
  end

  assign fields   = split_instr(instr_q);
  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc_plus1 = pc_plus1_q;
  assign opcode   = fields.opcode;
  assign rs       = fields.rs;
  assign rt       = fields.rt;
  assign rd       = fields.rd;
  assign funct    = fields.funct;
  assign imm6     = fields.imm6;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/ack FSM, stall hold buffer and redirect/flush.
// Optional fetch_count performance counter is built when IF_PERF_CNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                 PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  if_stage_if.master            imem,
  output logic                  ifid_valid,
  output logic [INSTR_W-1:0]    ifid_instr,
  output logic [PC_WIDTH-1:0]   ifid_pc_plus1,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [FUNCT_W-1:0]    funct,
  output logic [IMM6_W-1:0]     imm6
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]           fetch_count
`endif
);

  // state | meaning
  // IDLE  | one cycle after reset before the first request
  // FETCH | request pc, accept ack into IF/ID or the hold buffer
  // HOLD  | fetched word parked in hold_q while ID stalls; no request
  // DRAIN | redirected with a fetch in flight; wait for its ack and discard it

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [INSTR_W-1:0]  hold_q, hold_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                pipe_load, pipe_flush, accept;
  logic [INSTR_W-1:0]  pipe_instr;
  logic [PC_WIDTH-1:0] pipe_pc_plus1;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    hold_d        = hold_q;
    pipe_load     = 1'b0;
    pipe_flush    = 1'b0;
    pipe_instr    = imem.rdata;
    pipe_pc_plus1 = pc_inc;
    accept        = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.ack) begin
          if (redirect) begin
            pc_d       = redirect_pc;
            pipe_flush = 1'b1;
          end else if (!stall) begin
            pipe_load = 1'b1;
            pc_d      = pc_inc;
            accept    = 1'b1;
          end else begin
            hold_d  = imem.rdata;
            pc_d    = pc_inc;
            accept  = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          tgt_d      = redirect_pc;
          pipe_flush = 1'b1;
          state_d    = ST_DRAIN;
        end else if (!stall) begin
          pipe_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        // pc already points past the held word, so it is the held word's pc+1.
        if (redirect) begin
          pc_d       = redirect_pc;
          pipe_flush = 1'b1;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          pipe_load     = 1'b1;
          pipe_instr    = hold_q;
          pipe_pc_plus1 = pc_q;
          state_d       = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        pipe_flush = redirect;
        if (imem.ack) begin
          pc_d    = redirect ? redirect_pc : tgt_q;
          state_d = ST_FETCH;
        end else if (redirect) begin
          tgt_d = redirect_pc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
    end
  end

  // During DRAIN pc is untouched, so it still names the in-flight address.
  assign imem.req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem.addr = pc_q;

`ifdef IF_PERF_CNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (accept) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign fetch_count = count_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  ifid_pipe_reg #(.PC_WIDTH(PC_WIDTH)) u_ifid (
    .clock       (clock),
    .reset       (reset),
    .load        (pipe_load),
    .flush       (pipe_flush),
    .instr_in    (pipe_instr),
    .pc_plus1_in (pipe_pc_plus1),
    .valid       (ifid_valid),
    .instr       (ifid_instr),
    .pc_plus1    (ifid_pc_plus1),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .funct       (funct),
    .imm6        (imm6)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: imem model with programmable latency plus an in-order scoreboard.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [15:0] ifid_instr, ifid_pc_plus1;
  logic [3:0]  opcode;
  logic [2:0]  rs, rt, rd;
  logic [1:0]  funct;
  logic [5:0]  imm6;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  if_stage_if #(.ADDR_W(16)) bus ();

  if_stage #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem          (bus),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .funct         (funct),
    .imm6          (imm6)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc1;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_lat = 0;
  int   mem_cnt = 0;
  bit   draining = 0;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  // Memory model: answers the request seen this cycle after mem_lat waiting cycles.
  task automatic begin_cycle();
    @(negedge clock);
    if (bus.req) begin
      if (mem_cnt >= mem_lat) begin
        bus.ack   = 1'b1;
        bus.rdata = instr_of(bus.addr);
        mem_cnt   = 0;
      end else begin
        bus.ack   = 1'b0;
        bus.rdata = 16'hDEAD;
        mem_cnt++;
      end
    end else begin
      bus.ack   = 1'b0;
      bus.rdata = 16'hDEAD;
      mem_cnt   = 0;
    end
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    reset       = 1'b0;
  endtask

  // Scoreboard: ID consumes when valid && !stall; accepted acks are pushed in order.
  task automatic end_cycle();
    exp_t e;
    if (reset) begin
      sbq.delete();
      draining = 0;
    end else begin
      if (ifid_valid && !stall) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: got instr %h pc1 %h, expected nothing", ifid_instr, ifid_pc_plus1);
        end else begin
          e = sbq.pop_front();
          if (ifid_instr !== e.instr || ifid_pc_plus1 !== e.pc1 || opcode !== e.instr[15:12] ||
              rs !== e.instr[11:9] || rd !== e.instr[5:3] || imm6 !== e.instr[5:0]) begin
            n_err++;
            $display("FAIL sb_ifid: got instr %h pc1 %h op %h rd %h, expected instr %h pc1 %h",
                     ifid_instr, ifid_pc_plus1, opcode, rd, e.instr, e.pc1);
          end
        end
      end
      if (bus.req && bus.ack && !redirect && !draining)
        sbq.push_back('{instr: bus.rdata, pc1: bus.addr + 16'd1});
      if (bus.req && bus.ack) draining = 0;
      else if (bus.req && redirect) draining = 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      begin_cycle();
      reset = 1'b1;
      end_cycle();
    end
  endtask

  // Leaves the bench mid-cycle at the first cycle matching the condition.
  task automatic wait_ack_addr(input logic [15:0] a, input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      begin_cycle();
      if (bus.req && bus.ack && bus.addr == a) found = 1;
      else end_cycle();
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no ack for addr %h within budget", tag, a);
      begin_cycle();
    end
  endtask

  task automatic wait_pending(input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      begin_cycle();
      if (bus.req && !bus.ack) found = 1;
      else end_cycle();
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no pending request within budget", tag);
      begin_cycle();
    end
  endtask

  task automatic wait_any_ack(input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      begin_cycle();
      if (bus.req && bus.ack) found = 1;
      else end_cycle();
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no ack within budget", tag);
      begin_cycle();
    end
  endtask

  task automatic test_reset();
    mem_lat = 0;
    do_reset();
    begin_cycle();
    n_cmp++;
    if (bus.req !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0 || ifid_pc_plus1 !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: got req %b valid %b instr %h pc1 %h, expected 0 0 0000 0000",
               bus.req, ifid_valid, ifid_instr, ifid_pc_plus1);
    end
`ifdef IF_PERF_CNT_EN
    n_cmp++;
    if (fetch_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d expected 0", fetch_count);
    end
`endif
    end_cycle();
  endtask

  task automatic test_stream();
    for (int k = 0; k < 6; k++) begin
      begin_cycle();
      n_cmp++;
      if (bus.req !== 1'b1 || bus.addr !== 16'(k) || bus.ack !== 1'b1) begin
        n_err++;
        $display("FAIL stream_addr: got req %b addr %h expected 1 %h", bus.req, bus.addr, 16'(k));
      end
      if (k > 0) begin
        n_cmp++;
        if (ifid_valid !== 1'b1 || ifid_instr !== instr_of(16'(k - 1)) || ifid_pc_plus1 !== 16'(k)) begin
          n_err++;
          $display("FAIL stream_latency: got valid %b instr %h pc1 %h expected 1 %h %h",
                   ifid_valid, ifid_instr, ifid_pc_plus1, instr_of(16'(k - 1)), 16'(k));
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_stall();
    mem_lat = 0;
    do_reset();
    wait_ack_addr(16'h0004, "stall_find");
    stall = 1'b1;
    end_cycle();
    for (int i = 0; i < 2; i++) begin
      begin_cycle();
      n_cmp++;
      if (bus.req !== 1'b0 || ifid_valid !== 1'b1 || ifid_instr !== instr_of(16'h3)) begin
        n_err++;
        $display("FAIL stall_hold: got req %b valid %b instr %h expected 0 1 %h",
                 bus.req, ifid_valid, ifid_instr, instr_of(16'h3));
      end
      stall = (i == 0);
      end_cycle();
    end
    begin_cycle();
    n_cmp++;
    if (ifid_valid !== 1'b1 || ifid_instr !== instr_of(16'h4) || ifid_pc_plus1 !== 16'h5 ||
        bus.req !== 1'b1 || bus.addr !== 16'h5) begin
      n_err++;
      $display("FAIL stall_release: got instr %h pc1 %h req %b addr %h expected %h 0005 1 0005",
               ifid_instr, ifid_pc_plus1, bus.req, bus.addr, instr_of(16'h4));
    end
    end_cycle();
    run(3);
  endtask

  task automatic test_redirect_wait();
    logic [15:0] a;
    bit acked = 0;
    mem_lat = 2;
    wait_pending("rdw_find");
    a = bus.addr;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    end_cycle();
    for (int i = 0; i < 10 && !acked; i++) begin
      begin_cycle();
      n_cmp++;
      if (bus.req !== 1'b1 || bus.addr !== a || ifid_valid !== 1'b0) begin
        n_err++;
        $display("FAIL drain_hold: got req %b addr %h valid %b expected 1 %h 0", bus.req, bus.addr, ifid_valid, a);
      end
      acked = bus.ack;
      end_cycle();
    end
    begin_cycle();
    n_cmp++;
    if (bus.req !== 1'b1 || bus.addr !== 16'h0040 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_target: got req %b addr %h valid %b expected 1 0040 0", bus.req, bus.addr, ifid_valid);
    end
    end_cycle();
    run(8);
  endtask

  task automatic test_redirect_ack();
    mem_lat = 0;
    wait_any_ack("rda_find");
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    end_cycle();
    begin_cycle();
    n_cmp++;
    if (bus.addr !== 16'h0100 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_ack: got addr %h valid %b expected 0100 0", bus.addr, ifid_valid);
    end
    end_cycle();
    run(4);
  endtask

  task automatic test_wrap();
    wait_any_ack("wrap_find");
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    end_cycle();
    begin_cycle();
    n_cmp++;
    if (bus.addr !== 16'hFFFF || bus.ack !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_top: got addr %h expected ffff", bus.addr);
    end
    end_cycle();
    begin_cycle();
    n_cmp++;
    if (bus.addr !== 16'h0000 || ifid_pc_plus1 !== 16'h0000 || ifid_instr !== instr_of(16'hFFFF)) begin
      n_err++;
      $display("FAIL wrap: got addr %h pc1 %h instr %h expected 0000 0000 %h",
               bus.addr, ifid_pc_plus1, ifid_instr, instr_of(16'hFFFF));
    end
    end_cycle();
    run(3);
  endtask

  task automatic test_drain_reset();
    bit acked = 0;
    mem_lat = 3;
    wait_pending("dr_find");
    redirect = 1'b1;
    redirect_pc = 16'h0080;
    end_cycle();
    begin_cycle();
    if (!bus.ack) begin
      redirect = 1'b1;
      redirect_pc = 16'h0090;
    end
    acked = bus.ack;
    end_cycle();
    for (int i = 0; i < 10 && !acked; i++) begin
      begin_cycle();
      acked = bus.ack;
      end_cycle();
    end
    begin_cycle();
    n_cmp++;
    if (bus.req !== 1'b1 || bus.addr !== 16'h0090) begin
      n_err++;
      $display("FAIL drain_retarget: got req %b addr %h expected 1 0090", bus.req, bus.addr);
    end
    end_cycle();
    wait_pending("dr_find2");
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    end_cycle();
    begin_cycle();
    reset = 1'b1;
    end_cycle();
    mem_lat = 0;
    begin_cycle();
    n_cmp++;
    if (bus.req !== 1'b0 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_reset: got req %b valid %b expected 0 0", bus.req, ifid_valid);
    end
`ifdef IF_PERF_CNT_EN
    n_cmp++;
    if (fetch_count !== 16'd0) begin
      n_err++;
      $display("FAIL drain_reset_count: got %0d expected 0", fetch_count);
    end
`endif
    end_cycle();
    begin_cycle();
    n_cmp++;
    if (bus.req !== 1'b1 || bus.addr !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_pc: got req %b addr %h expected 1 0000", bus.req, bus.addr);
    end
    end_cycle();
    run(4);
    begin_cycle();
    n_cmp++;
    if (bus.addr !== 16'h0005) begin
      n_err++;
      $display("FAIL post_reset_addr: got %h expected 0005", bus.addr);
    end
`ifdef IF_PERF_CNT_EN
    n_cmp++;
    if (fetch_count !== 16'd5) begin
      n_err++;
      $display("FAIL fetch_count: got %0d expected 5", fetch_count);
    end
`endif
    end_cycle();
  endtask

  initial begin
    bus.ack   = 1'b0;
    bus.rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_drain_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
